mesh_tile_engine: RTL

- Parametrised rectangular (ROWS x COLS) output-stationary systolic mesh for tiled matrix multiply, computing C = A x B.
- Generalises the square NxN mesh in four ways: non-square geometry, built-in input skew, bubble-tolerant valid tracking, and an integrated flush/drain FSM.
- The drain FSM streams accumulated results out one row per beat over a valid/ready handshake.
- Sits between the operand input queues and the result writeback buffer.

---
 rtl/mesh_pkg.sv | 26 ++
 rtl/mesh_tile_engine_pe.sv | 47 ++++
 rtl/mesh_tile_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// mesh_pkg: shared state encoding, default geometry and helpers for the systolic tile engine.
package mesh_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } mesh_state_e;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;

  // Cycles needed for the last accepted beat to reach PE(ROWS-1, COLS-1).
  localparam int FLUSH_CYCLES = DEF_ROWS + DEF_COLS - 1;

  // Accumulator type at the default width; the top re-declares it for its own ACC_WIDTH.
  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/mesh_tile_engine_pe.sv
// mesh_mac_pe: one output-stationary PE; forwards operands east/south and accumulates a*b.
module mesh_mac_pe
  import mesh_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] a_west,
  input  logic                  v_west,
  input  logic [DATA_WIDTH-1:0] b_north,
  input  logic                  v_north,
  output logic [DATA_WIDTH-1:0] a_east,
  output logic                  v_east,
  output logic [DATA_WIDTH-1:0] b_south,
  output logic                  v_south,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = $signed(a_west) * $signed(b_north);

  // Pass operands on one cycle later and accumulate the sign-extended product of valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_east  <= '0;
      v_east  <= 1'b0;
      b_south <= '0;
      v_south <= 1'b0;
      acc     <= '0;
    end else begin
      a_east  <= a_west;
      v_east  <= v_west;
      b_south <= b_north;
      v_south <= v_north;
      if (clr) begin
        acc <= '0;
      end else if (v_west && v_north) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

endmodule

// File: rtl/mesh_tile_engine.sv
// mesh_tile_engine: ROWS x COLS output-stationary systolic mesh with input skew and a row drain FSM.
module mesh_tile_engine
  import mesh_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [ROWS*DATA_WIDTH-1:0]                a_i,
  input  logic [COLS*DATA_WIDTH-1:0]                b_i,
  input  logic                                      in_valid_i,
  input  logic                                      in_last_i,
  output logic                                      in_ready_o,
  output logic [COLS*ACC_WIDTH-1:0]                 out_data_o,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_o,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic                                      busy_o,
  output logic                                      done_o
);

  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LEN = flush_cycles(ROWS, COLS);
  localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

  typedef logic [ACC_WIDTH-1:0] tile_acc_t;

  mesh_state_e      state;
  logic [CNT_W-1:0] flush_cnt;
  logic [ROW_W-1:0] row_q;
  logic             beat;
  logic             row_hs;
  logic             last_row;

  logic [DATA_WIDTH-1:0] west_a  [ROWS];
  logic                  west_v  [ROWS];
  logic [DATA_WIDTH-1:0] north_b [COLS];
  logic                  north_v [COLS];
  logic [DATA_WIDTH-1:0] a_pass  [ROWS][COLS];
  logic                  va_pass [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_pass  [ROWS][COLS];
  logic                  vb_pass [ROWS][COLS];
  tile_acc_t             acc     [ROWS][COLS];

  assign in_ready_o  = (state == IDLE) || (state == COMPUTE);
  assign beat        = in_valid_i && in_ready_o;
  assign out_valid_o = (state == DRAIN);
  assign row_hs      = out_valid_o && out_ready_i;
  assign last_row    = (row_q == ROW_W'(ROWS - 1));
  assign done_o      = row_hs && last_row;
  assign busy_o      = (state != IDLE);
  assign out_row_o   = row_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_west
    if (r == 0) begin : g_direct
      assign west_a[r] = a_i[r*DATA_WIDTH +: DATA_WIDTH];
      assign west_v[r] = beat;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] skew_a [r];
      logic                  skew_v [r];

      // Delay west lane r by r cycles so row r meets its B operands in step.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < r; i++) begin
            skew_a[i] <= '0;
            skew_v[i] <= 1'b0;
          end
        end else begin
          skew_a[0] <= a_i[r*DATA_WIDTH +: DATA_WIDTH];
          skew_v[0] <= beat;
          for (int i = 1; i < r; i++) begin
            skew_a[i] <= skew_a[i-1];
            skew_v[i] <= skew_v[i-1];
          end
        end
      end

      assign west_a[r] = skew_a[r-1];
      assign west_v[r] = skew_v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_north
    if (c == 0) begin : g_direct
      assign north_b[c] = b_i[c*DATA_WIDTH +: DATA_WIDTH];
      assign north_v[c] = beat;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] skew_b [c];
      logic                  skew_v [c];

      // Delay north lane c by c cycles so column c meets its A operands in step.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < c; i++) begin
            skew_b[i] <= '0;
            skew_v[i] <= 1'b0;
          end
        end else begin
          skew_b[0] <= b_i[c*DATA_WIDTH +: DATA_WIDTH];
          skew_v[0] <= beat;
          for (int i = 1; i < c; i++) begin
            skew_b[i] <= skew_b[i-1];
            skew_v[i] <= skew_v[i-1];
          end
        end
      end

      assign north_b[c] = skew_b[c-1];
      assign north_v[c] = skew_v[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_WIDTH-1:0] pe_a;
      logic                  pe_va;
      logic [DATA_WIDTH-1:0] pe_b;
      logic                  pe_vb;

      if (c == 0) begin : g_edge_w
        assign pe_a  = west_a[r];
        assign pe_va = west_v[r];
      end else begin : g_inner_w
        assign pe_a  = a_pass[r][c-1];
        assign pe_va = va_pass[r][c-1];
      end

      if (r == 0) begin : g_edge_n
        assign pe_b  = north_b[c];
        assign pe_vb = north_v[c];
      end else begin : g_inner_n
        assign pe_b  = b_pass[r-1][c];
        assign pe_vb = vb_pass[r-1][c];
      end

      mesh_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (done_o),
        .a_west  (pe_a),
        .v_west  (pe_va),
        .b_north (pe_b),
        .v_north (pe_vb),
        .a_east  (a_pass[r][c]),
        .v_east  (va_pass[r][c]),
        .b_south (b_pass[r][c]),
        .v_south (vb_pass[r][c]),
        .acc     (acc[r][c])
      );
    end
  end

  // Tile sequencing: accept beats, wait for the wavefront to settle, then drain one row per handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      flush_cnt <= '0;
      row_q     <= '0;
    end else begin
      case (state)
        IDLE, COMPUTE: begin
          if (beat) begin
            state     <= in_last_i ? FLUSH : COMPUTE;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt == CNT_W'(FLUSH_LEN - 1)) begin
            state     <= DRAIN;
            flush_cnt <= '0;
            row_q     <= '0;
          end else begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (row_hs) begin
            if (last_row) begin
              state <= IDLE;
              row_q <= '0;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Present the selected accumulator row only while draining; zero otherwise.
  always_comb begin
    out_data_o = '0;
    if (state == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_data_o[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][c];
      end
    end
  end

endmodule
